fp_div_sequencer: RTL and testbench



---
 rtl/fp_div_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sequencer.sv
// Multi-cycle IEEE-754 divider sequencer: operand handshake, special-case
// screening, radix-2 restoring mantissa division, normalize, RNE round,
// result handshake. Subnormal inputs are treated as zero; tiny results flush to zero.
module fp_div_sequencer #(
    parameter int unsigned BUS_WIDTH     = 64,
    parameter int unsigned EXPONENT_SIZE = 11,
    parameter int unsigned MANTISSA_SIZE = 52,
    parameter int unsigned BIAS          = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] op_a,
    input  logic [BUS_WIDTH-1:0] op_b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] result,
    output logic [4:0]           flags
);

    localparam int unsigned W    = BUS_WIDTH;
    localparam int unsigned EW   = EXPONENT_SIZE;
    localparam int unsigned M    = MANTISSA_SIZE;
    localparam int unsigned EXPW = EW + 2;
    localparam int unsigned QW   = M + 4;
    localparam int unsigned RW   = M + 2;
    localparam int unsigned CW   = $clog2(M + 4);

    localparam logic [CW-1:0]          LAST_ITER = CW'(M + 3);
    localparam logic signed [EXPW-1:0] EXP_MAX   = EXPW'((1 << EW) - 1);
    localparam logic [W-1:0]           QNAN      = {1'b0, {EW{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, SPECIAL, DIVIDE, NORMALIZE, ROUND, DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [QW-1:0]           q_q, q_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [EXPW-1:0]  exp_q, exp_d;
    logic [M-1:0]            frac_q, frac_d;
    logic                    g_q, g_d, s_q, s_d;
    logic [W-1:0]            result_q, result_d;
    logic [4:0]              flags_q, flags_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;

    // Operand field decode (incoming and latched)
    logic [EW-1:0] ea_in, eb_in, ea, eb;
    logic [M-1:0]  fa, fb;
    logic          in_special, sign_r;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign ea_in      = op_a[M +: EW];
    assign eb_in      = op_b[M +: EW];
    assign in_special = (&ea_in) | (~|ea_in) | (&eb_in) | (~|eb_in);
    assign ea         = a_q[M +: EW];
    assign eb         = b_q[M +: EW];
    assign fa         = a_q[M-1:0];
    assign fb         = b_q[M-1:0];
    assign sign_r     = a_q[W-1] ^ b_q[W-1];
    assign a_nan      = (&ea) & (|fa);
    assign b_nan      = (&eb) & (|fb);
    assign a_inf      = (&ea) & ~(|fa);
    assign b_inf      = (&eb) & ~(|fb);
    assign a_zero     = ~|ea;
    assign b_zero     = ~|eb;

    // Restoring-division step and rounding helpers
    logic [RW-1:0]          div_ext, rem_diff;
    logic                   rem_ge, round_up, rnd_carry;
    logic [M-1:0]           rnd_frac;
    logic signed [EXPW-1:0] exp_rnd;

    assign div_ext               = {1'b0, 1'b1, fb};
    assign rem_ge                = rem_q >= div_ext;
    assign rem_diff              = rem_q - div_ext;
    assign round_up              = g_q & (s_q | frac_q[0]);
    assign {rnd_carry, rnd_frac} = {1'b0, frac_q} + (M+1)'(round_up);
    assign exp_rnd               = exp_q + EXPW'(rnd_carry);

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        frac_d      = frac_q;
        g_d         = g_q;
        s_d         = s_q;
        result_d    = result_q;
        flags_d     = flags_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    rem_d   = {2'b01, op_a[M-1:0]};
                    q_d     = '0;
                    cnt_d   = '0;
                    exp_d   = EXPW'(ea_in) - EXPW'(eb_in) + EXPW'(BIAS);
                    state_d = in_special ? SPECIAL : DIVIDE;
                end
            end
            SPECIAL: begin
                flags_d = '0;
                if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                    result_d = QNAN;
                    flags_d  = 5'b10000;
                end else if (a_inf) begin
                    result_d = {sign_r, {EW{1'b1}}, {M{1'b0}}};
                end else if (b_zero) begin
                    result_d = {sign_r, {EW{1'b1}}, {M{1'b0}}};
                    flags_d  = 5'b01000;
                end else begin
                    result_d = {sign_r, {(W-1){1'b0}}};
                end
                state_d = DONE;
            end
            DIVIDE: begin
                q_d   = {q_q[QW-2:0], rem_ge};
                rem_d = RW'((rem_ge ? rem_diff : rem_q) << 1);
                if (cnt_q == LAST_ITER) begin
                    state_d = NORMALIZE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NORMALIZE: begin
                if (q_q[QW-1]) begin
                    frac_d = q_q[M+2:3];
                    g_d    = q_q[2];
                    s_d    = (|q_q[1:0]) | (|rem_q);
                end else begin
                    frac_d = q_q[M+1:2];
                    g_d    = q_q[1];
                    s_d    = q_q[0] | (|rem_q);
                    exp_d  = exp_q - EXPW'(1);
                end
                state_d = ROUND;
            end
            ROUND: begin
                if (exp_rnd >= EXP_MAX) begin
                    result_d = {sign_r, {EW{1'b1}}, {M{1'b0}}};
                    flags_d  = 5'b00101;
                end else if (exp_rnd[EXPW-1] | (exp_rnd == '0)) begin
                    result_d = {sign_r, {(W-1){1'b0}}};
                    flags_d  = 5'b00011;
                end else begin
                    result_d = {sign_r, exp_rnd[EW-1:0], rnd_frac};
                    flags_d  = {4'b0000, g_q | s_q};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort discards the in-flight op; idle is unaffected
        if (flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            result_d = '0;
            flags_d  = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            frac_q      <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
            g_q         <= g_d;
            s_q         <= s_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Self-checking bench for fp_div_sequencer: directed cases plus random
// operands checked against a real-arithmetic reference model.
module tb_fp_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    fp_div_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: classification rules for specials, real division otherwise
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [4:0] f);
        logic [10:0]  ea, eb;
        logic [51:0]  fa, fb;
        logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        real          q;
        logic [63:0]  qb;
        logic [127:0] ma, mb;
        int           t;
        ea = a[62:52]; eb = b[62:52]; fa = a[51:0]; fb = b[51:0];
        s = a[63] ^ b[63];
        a_nan = (ea == 11'h7FF) && (fa != 0);
        b_nan = (eb == 11'h7FF) && (fb != 0);
        a_inf = (ea == 11'h7FF) && (fa == 0);
        b_inf = (eb == 11'h7FF) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        r = '0;
        f = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            r = 64'h7FF8000000000000; f = 5'b10000;
        end else if (a_inf) begin
            r = {s, 11'h7FF, 52'h0};
        end else if (b_zero) begin
            r = {s, 11'h7FF, 52'h0}; f = 5'b01000;
        end else if (a_zero || b_inf) begin
            r = {s, 63'h0};
        end else begin
            q  = $bitstoreal(a) / $bitstoreal(b);
            qb = $realtobits(q);
            if (qb[62:52] == 11'h7FF) begin
                r = {s, 11'h7FF, 52'h0}; f = 5'b00101;
            end else if (qb[62:52] == 11'h000) begin
                r = {s, 63'h0}; f = 5'b00011;
            end else begin
                r  = qb;
                ma = {75'h0, 1'b1, fa};
                mb = {75'h0, 1'b1, fb};
                t  = (ma >= mb) ? 52 : 53;
                f  = {4'b0000, ((ma << t) % mb) != 0};
            end
        end
    endfunction

    function automatic logic [63:0] gen_operand(input bit allow_special);
        logic [63:0] v;
        int          cls;
        v[63]    = 1'($urandom);
        v[51:0]  = {20'($urandom), 32'($urandom)};
        v[62:52] = 11'($urandom_range(600, 1400));
        cls = allow_special ? int'($urandom_range(0, 7)) : 7;
        case (cls)
            0: begin v[62:52] = 11'h000; v[51:0] = '0; end
            1: begin v[62:52] = 11'h7FF; v[51:0] = '0; end
            2: begin v[62:52] = 11'h7FF; v[51] = 1'b1; end
            3: begin v[62:52] = 11'h000; v[0] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    // One transaction: accept, measure latency, optional backpressure, handoff
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int hold,
                          output logic [63:0] res, output logic [4:0] fl, output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1; op_a = a; op_b = b;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk); guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk); lat++;
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
        res = result;
        fl  = flags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_result", result, res);
            check("bp_ctl", 64'({out_valid, in_ready, flags}), 64'({1'b1, 1'b0, fl}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_handoff", 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    // Start an op, interrupt it at DIVIDE iteration 20 by reset or flush
    task automatic abort_op(input bit use_reset);
        int highs;
        @(negedge clk);
        in_valid = 1'b1; op_a = 64'h4018000000000000; op_b = 64'h4000000000000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0;
        check(use_reset ? "rst_ctl" : "flush_ctl", 64'({out_valid, in_ready}), 64'(2'b01));
        check(use_reset ? "rst_result" : "flush_result", result, 64'h0);
        check(use_reset ? "rst_flags" : "flush_flags", 64'(flags), 64'h0);
        highs = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) highs++;
        end
        check(use_reset ? "rst_no_stale" : "flush_no_stale", 64'(highs), 64'd0);
    endtask

    logic [63:0] r, er, ra, rb;
    logic [4:0]  f, ef;
    int          lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_ctl", 64'({out_valid, in_ready}), 64'(2'b01));
        check("reset_result", result, 64'h0);
        check("reset_flags", 64'(flags), 64'h0);

        run_op(64'h4018000000000000, 64'h4000000000000000, 0, r, f, lat);
        check("6/2 result", r, 64'h4008000000000000);
        check("6/2 flags", 64'(f), 64'h0);
        check("6/2 latency", 64'(lat), 64'd59);

        run_op(64'h3FF0000000000000, 64'h4008000000000000, 0, r, f, lat);
        check("1/3 result", r, 64'h3FD5555555555555);
        check("1/3 flags", 64'(f), 64'h01);

        run_op(64'hBFF8000000000000, 64'h3FE0000000000000, 0, r, f, lat);
        check("-1.5/0.5 result", r, 64'hC008000000000000);
        check("-1.5/0.5 flags", 64'(f), 64'h0);

        run_op(64'h3FF0000000000000, 64'h0000000000000000, 0, r, f, lat);
        check("1/0 result", r, 64'h7FF0000000000000);
        check("1/0 flags", 64'(f), 64'h08);
        check("1/0 latency", 64'(lat), 64'd2);

        run_op(64'h0000000000000000, 64'h0000000000000000, 0, r, f, lat);
        check("0/0 result", r, 64'h7FF8000000000000);
        check("0/0 flags", 64'(f), 64'h10);
        check("0/0 latency", 64'(lat), 64'd2);

        run_op(64'h7FF0000000000000, 64'h4000000000000000, 0, r, f, lat);
        check("inf/2 result", r, 64'h7FF0000000000000);
        check("inf/2 flags", 64'(f), 64'h0);
        check("inf/2 latency", 64'(lat), 64'd2);

        run_op(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 0, r, f, lat);
        check("ovf result", r, 64'h7FF0000000000000);
        check("ovf flags", 64'(f), 64'h05);

        run_op(64'h8010000000000000, 64'h4000000000000000, 0, r, f, lat);
        check("unf result", r, 64'h8000000000000000);
        check("unf flags", 64'(f), 64'h03);

        // Flush while idle leaves the held result alone
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("idle_flush_result", result, 64'h8000000000000000);
        check("idle_flush_ready", 64'(in_ready), 64'd1);

        run_op(64'h4018000000000000, 64'h4000000000000000, 10, r, f, lat);
        check("bp result", r, 64'h4008000000000000);
        run_op(64'h3FF0000000000000, 64'h4008000000000000, 0, r, f, lat);
        check("after_bp result", r, 64'h3FD5555555555555);
        check("after_bp flags", 64'(f), 64'h01);

        abort_op(1'b1);
        run_op(64'h4018000000000000, 64'h4000000000000000, 0, r, f, lat);
        check("after_rst result", r, 64'h4008000000000000);

        abort_op(1'b0);
        run_op(64'h4018000000000000, 64'h4000000000000000, 0, r, f, lat);
        check("after_flush result", r, 64'h4008000000000000);

        for (int i = 0; i < 40; i++) begin
            ra = gen_operand(i % 4 == 3);
            rb = gen_operand(i % 4 == 3);
            ref_div(ra, rb, er, ef);
            run_op(ra, rb, int'($urandom_range(0, 2)), r, f, lat);
            check("rand result", r, er);
            check("rand flags", 64'(f), 64'(ef));
            check("rand latency", 64'(lat),
                  ((ra[62:52] == 11'h7FF) || (ra[62:52] == 11'h000) ||
                   (rb[62:52] == 11'h7FF) || (rb[62:52] == 11'h000)) ? 64'd2 : 64'd59);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
